// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: IDLE -> DRIVE -> LOAD per transfer, rejecting illegal sources with err.
// Define BUS_ARB_BACK2BACK_EN to re-arbitrate in LOAD for a 2-cycle transfer period.
module bus_arbiter #(
  parameter int NCORES = 4,
  parameter int SEL_W  = 5,
  parameter int LD_W   = 17
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCORES-1:0]       req,
  input  logic [NCORES*SEL_W-1:0] src_sel,
  input  logic [NCORES*LD_W-1:0]  dst_ld,
  output logic [SEL_W-1:0]        mux_sel,
  output logic [LD_W-1:0]         ld_en,
  output logic [NCORES-1:0]       grant,
  output logic [NCORES-1:0]       done,
  output logic [NCORES-1:0]       err,
  output logic                    busy
);

  localparam int PTR_W   = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int SRC_MAX = 17;

  typedef enum logic [1:0] {IDLE, DRIVE, LOAD} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    rr_q, rr_d, win_q, win_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [LD_W-1:0]     ld_q, ld_d;
  logic [NCORES-1:0]   err_q, err_d;

  logic [NCORES-1:0]   arb_req;
  logic [PTR_W-1:0]    arb_ptr, pick;
  logic                pick_vld, pick_ok;
  logic [SEL_W-1:0]    pick_sel;
  logic [LD_W-1:0]     pick_ld;
  logic [NCORES-1:0]   own_oh;
  int                  idx;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (int'(p) == NCORES - 1) ? '0 : p + 1'b1;
  endfunction

  assign own_oh = NCORES'(1) << win_q;

  // In LOAD the completing core is masked and the search starts just past it.
  always_comb begin
    arb_req = req;
    arb_ptr = rr_q;
    if (state_q == LOAD) begin
      arb_req = req & ~own_oh;
      arb_ptr = inc_ptr(win_q);
    end
  end

  // Scan from the highest offset down so the nearest requester to arb_ptr wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      idx = (int'(arb_ptr) + i) % NCORES;
      if (arb_req[idx]) begin
        pick     = PTR_W'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign pick_sel = src_sel[pick*SEL_W +: SEL_W];
  assign pick_ld  = dst_ld[pick*LD_W +: LD_W];
  assign pick_ok  = (pick_sel != '0) && (int'(pick_sel) <= SRC_MAX) && (pick_ld != '0);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    win_d   = win_q;
    sel_d   = sel_q;
    ld_d    = ld_q;
    err_d   = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          if (pick_ok) begin
            win_d   = pick;
            sel_d   = pick_sel;
            ld_d    = pick_ld;
            state_d = DRIVE;
          end else begin
            err_d[pick] = 1'b1;
            rr_d        = inc_ptr(pick);
          end
        end
      end
      DRIVE: state_d = LOAD;
      LOAD: begin
        rr_d    = inc_ptr(win_q);
        state_d = IDLE;
`ifdef BUS_ARB_BACK2BACK_EN
        if (pick_vld) begin
          if (pick_ok) begin
            win_d   = pick;
            sel_d   = pick_sel;
            ld_d    = pick_ld;
            state_d = DRIVE;
          end else begin
            err_d[pick] = 1'b1;
            rr_d        = inc_ptr(pick);
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      win_q   <= '0;
      sel_q   <= '0;
      ld_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      sel_q   <= sel_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
    end
  end

  assign mux_sel = (state_q != IDLE) ? sel_q : '0;
  assign grant   = (state_q != IDLE) ? own_oh : '0;
  assign ld_en   = (state_q == LOAD) ? ld_q : '0;
  assign done    = (state_q == LOAD) ? own_oh : '0;
  assign err     = err_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed vector table, round-robin order/period sequence, and
// randomized traffic against a timeline-based reference model.
module tb_bus_arbiter;
  localparam int NC = 4, SW = 5, LW = 17;
`ifdef BUS_ARB_BACK2BACK_EN
  localparam int PERIOD = 2;
`else
  localparam int PERIOD = 3;
`endif

  logic              clk = 1'b0, rst = 1'b1;
  logic [NC-1:0]     req = '0;
  logic [NC*SW-1:0]  src_sel = '0;
  logic [NC*LW-1:0]  dst_ld = '0;
  logic [SW-1:0]     mux_sel;
  logic [LW-1:0]     ld_en;
  logic [NC-1:0]     grant, done, err;
  logic              busy;

  bus_arbiter #(.NCORES(NC), .SEL_W(SW), .LD_W(LW)) dut (
    .clk(clk), .rst(rst), .req(req), .src_sel(src_sel), .dst_ld(dst_ld),
    .mux_sel(mux_sel), .ld_en(ld_en), .grant(grant), .done(done), .err(err), .busy(busy));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SW-1:0] mux;
    logic [LW-1:0] ld;
    logic [NC-1:0] grant;
    logic [NC-1:0] done;
    logic [NC-1:0] err;
    logic          busy;
  } outs_t;

  typedef struct {
    logic          r;
    logic [NC-1:0] rq;
    logic [NC*SW-1:0] s;
    logic [NC*LW-1:0] d;
    outs_t         exp;
  } vec_t;

  int n_chk = 0, n_fail = 0;
  vec_t vq[$];
  logic [NC*SW-1:0] s_tab = '0;
  logic [NC*LW-1:0] d_tab = '0;

  // Reference model: expected outputs of the current cycle plus one cycle ahead.
  outs_t cur = '0, pend1 = '0, prev = '0;
  int    mptr = 0;
  bit    model_on = 1'b0;

  function automatic outs_t dut_outs();
    return '{mux: mux_sel, ld: ld_en, grant: grant, done: done, err: err, busy: busy};
  endfunction

  task automatic chk(input string name, input outs_t act, input outs_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got mux=%h ld=%h gnt=%b done=%b err=%b busy=%b want mux=%h ld=%h gnt=%b done=%b err=%b busy=%b",
               name, $time, act.mux, act.ld, act.grant, act.done, act.err, act.busy,
               exp.mux, exp.ld, exp.grant, exp.done, exp.err, exp.busy);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic model_arb(input logic [NC-1:0] r);
    bit found = 1'b0;
    for (int k = 0; k < NC; k++) begin
      int c = (mptr + k) % NC;
      if (!found && r[c]) begin
        int code = int'(src_sel[c*SW +: SW]);
        logic [LW-1:0] dl = dst_ld[c*LW +: LW];
        found = 1'b1;
        mptr  = (c + 1) % NC;
        cur   = '0;
        if (code >= 1 && code <= 17 && dl != '0) begin
          cur.mux   = SW'(code);
          cur.grant = NC'(1) << c;
          cur.busy  = 1'b1;
          pend1      = cur;
          pend1.ld   = dl;
          pend1.done = NC'(1) << c;
        end else begin
          cur.err[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic model_edge();
    prev  = cur;
    cur   = pend1;
    pend1 = '0;
    if (rst) begin
      cur = '0; mptr = 0;
    end else if (!prev.busy) begin
      model_arb(req);
`ifdef BUS_ARB_BACK2BACK_EN
    end else if (prev.done != '0 && (req & ~prev.done) != '0) begin
      model_arb(req & ~prev.done);
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    model_on = 1'b1;
    @(negedge clk);
    chk("model", dut_outs(), cur);
  endtask

  task automatic v(input logic r, input logic [NC-1:0] rq, input int c, input int code, input int dl,
                   input int emux, input int eld, input int egr, input int edn, input int eer, input int eb);
    vec_t t;
    if (c >= 0) begin
      s_tab[c*SW +: SW] = SW'(code);
      d_tab[c*LW +: LW] = LW'(dl);
    end
    t.r = r; t.rq = rq; t.s = s_tab; t.d = d_tab;
    t.exp = '{mux: SW'(emux), ld: LW'(eld), grant: NC'(egr), done: NC'(edn), err: NC'(eer), busy: eb[0]};
    vq.push_back(t);
  endtask

  initial begin
    int drv_cyc[$];
    int drv_gnt[$];
    int cyc;
    logic [NC-1:0] pr;
    // rst, req, core, code, dst  |  mux, ld, grant, done, err, busy (after the edge)
    v(1, 4'b0000, -1, 0, 0,          0, 0, 0, 0, 0, 0);
    v(0, 4'b0001, 0, 'h0D, 'h00100,  'h0D, 0, 1, 0, 0, 1);
    v(0, 4'b0000, -1, 0, 0,          'h0D, 'h00100, 1, 1, 0, 1);
    v(0, 4'b0000, -1, 0, 0,          0, 0, 0, 0, 0, 0);
    v(0, 4'b0010, 1, 'h00, 'h1,      0, 0, 0, 0, 'b0010, 0);
    v(0, 4'b0110, 2, 'h03, 'h1FFFF,  'h03, 0, 'b0100, 0, 0, 1);
    v(0, 4'b0000, -1, 0, 0,          'h03, 'h1FFFF, 'b0100, 'b0100, 0, 1);
    v(0, 4'b0000, -1, 0, 0,          0, 0, 0, 0, 0, 0);
    v(0, 4'b1000, 3, 'h11, 'h1,      'h11, 0, 'b1000, 0, 0, 1);
    v(1, 4'b1000, -1, 0, 0,          0, 0, 0, 0, 0, 0);
    v(0, 4'b1001, 0, 'h01, 'h2,      'h01, 0, 'b0001, 0, 0, 1);
    v(0, 4'b0000, -1, 0, 0,          'h01, 'h2, 'b0001, 'b0001, 0, 1);
    v(0, 4'b0000, -1, 0, 0,          0, 0, 0, 0, 0, 0);
    v(0, 4'b0010, 1, 'h12, 'h1,      0, 0, 0, 0, 'b0010, 0);
    v(0, 4'b0100, 2, 'h05, 'h0,      0, 0, 0, 0, 'b0100, 0);
    v(0, 4'b1000, 3, 'h07, 'h0ABCD,  'h07, 0, 'b1000, 0, 0, 1);
    v(0, 4'b0000, 3, 'h1E, 'h1,      'h07, 'h0ABCD, 'b1000, 'b1000, 0, 1);
    v(0, 4'b0000, -1, 0, 0,          0, 0, 0, 0, 0, 0);

    @(negedge clk);
    foreach (vq[k]) begin
      rst = vq[k].r; req = vq[k].rq; src_sel = vq[k].s; dst_ld = vq[k].d;
      tick();
      chk($sformatf("vec%0d", k), dut_outs(), vq[k].exp);
    end

    // All four cores requesting continuously: order and transfer period.
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0; req = 4'b1111;
    for (int c = 0; c < NC; c++) begin
      src_sel[c*SW +: SW] = SW'(c + 2);
      dst_ld[c*LW +: LW]  = LW'(c + 1);
    end
    cyc = 0;
    while (drv_cyc.size() < 5 && cyc < 40) begin
      tick();
      cyc++;
      if (grant != '0 && ld_en == '0) begin
        drv_cyc.push_back(cyc);
        drv_gnt.push_back(int'(grant));
      end
    end
    chk_int("rr_grants_seen", drv_cyc.size(), 5);
    if (drv_cyc.size() == 5) begin
      chk_int("rr_g0", drv_gnt[0], 1);
      chk_int("rr_g1", drv_gnt[1], 2);
      chk_int("rr_g2", drv_gnt[2], 4);
      chk_int("rr_g3", drv_gnt[3], 8);
      chk_int("rr_g4", drv_gnt[4], 1);
      for (int k = 1; k < 5; k++) chk_int($sformatf("rr_period%0d", k), drv_cyc[k] - drv_cyc[k-1], PERIOD);
    end

    // Randomized traffic against the model.
    pr = '0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, 3) == 0) pr[c] = ~pr[c];
        if ($urandom_range(0, 3) == 0) begin
          src_sel[c*SW +: SW] = SW'($urandom_range(0, 19));
          dst_ld[c*LW +: LW]  = ($urandom_range(0, 7) == 0) ? '0 : LW'($urandom);
        end
      end
      req = pr;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
